// File: rtl/baej_reg_file.sv
// Architectural register file with a LIFO stack of full-file shadow windows for cal/ret.
// Optional macro BAEJ_RF_BYPASS_EN enables write-to-read forwarding on both read ports.
module baej_reg_file #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NREG    = 16,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned RET_REG = 1
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic                       RegR1,
    input  logic                       RegR2,
    input  logic [$clog2(NREG)-1:0]    ra1,
    input  logic [$clog2(NREG)-1:0]    ra2,
    input  logic                       RegW1,
    input  logic [$clog2(NREG)-1:0]    wa1,
    input  logic [WIDTH-1:0]           wd1,
    input  logic                       RegW2,
    input  logic [$clog2(NREG)-1:0]    wa2,
    input  logic [WIDTH-1:0]           wd2,
    input  logic                       backup,
    input  logic                       restore,
    output logic [WIDTH-1:0]           rd1,
    output logic [WIDTH-1:0]           rd2,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       proto_err
);

    localparam int unsigned AW = $clog2(NREG);
    localparam int unsigned DW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] regs_q    [NREG];
    logic [WIDTH-1:0] regs_d    [NREG];
    logic [WIDTH-1:0] regs_nxt  [NREG];
    logic [WIDTH-1:0] top_win   [NREG];
    logic [WIDTH-1:0] stack_q   [DEPTH][NREG];
    logic [WIDTH-1:0] stack_d   [DEPTH][NREG];

    logic [DW-1:0]    depth_q, depth_d;
    logic [WIDTH-1:0] rd1_q, rd1_d;
    logic [WIDTH-1:0] rd2_q, rd2_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             perr_q, perr_d;

    logic             full_c;
    logic             empty_c;
    logic             do_push_c;
    logic             do_pop_c;

    assign full_c  = (depth_q == DW'(DEPTH));
    assign empty_c = (depth_q == DW'(0));

    // Simultaneous backup+restore cancels both stack operations.
    assign do_push_c = backup  && !restore && !full_c;
    assign do_pop_c  = restore && !backup  && !empty_c;

    // Live register file: port writes first, then a restore overrides all but RET_REG.
    always_comb begin
        regs_nxt = regs_q;
        top_win  = stack_q[SW'(depth_q - DW'(1))];
        if (RegW1) begin
            regs_nxt[wa1] = wd1;
        end
        if (RegW2) begin
            regs_nxt[wa2] = wd2;
        end
        if (do_pop_c) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (i != RET_REG) begin
                    regs_nxt[AW'(i)] = top_win[AW'(i)];
                end
            end
        end
    end

    // Stack, depth and sticky error flags; snapshots use pre-edge register values.
    always_comb begin
        stack_d = stack_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        perr_d  = perr_q;
        if (backup && restore) begin
            perr_d = 1'b1;
        end else if (backup) begin
            if (full_c) begin
                ovf_d = 1'b1;
            end
        end else if (restore) begin
            if (empty_c) begin
                udf_d = 1'b1;
            end
        end
        if (do_push_c) begin
            stack_d[SW'(depth_q)] = regs_q;
            depth_d               = depth_q + DW'(1);
        end else if (do_pop_c) begin
            depth_d = depth_q - DW'(1);
        end
        if (Reset) begin
            depth_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
            perr_d  = 1'b0;
        end
    end

    // Read ports latch on their strobes and hold otherwise.
    always_comb begin
        rd1_d = rd1_q;
        rd2_d = rd2_q;
`ifdef BAEJ_RF_BYPASS_EN
        if (RegR1) begin
            rd1_d = regs_nxt[ra1];
        end
        if (RegR2) begin
            rd2_d = regs_nxt[ra2];
        end
`else
        if (RegR1) begin
            rd1_d = regs_q[ra1];
        end
        if (RegR2) begin
            rd2_d = regs_q[ra2];
        end
`endif
        regs_d = regs_nxt;
        if (Reset) begin
            rd1_d  = '0;
            rd2_d  = '0;
            regs_d = '{default: '0};
        end
    end

    always_ff @(posedge clk) begin
        regs_q  <= regs_d;
        stack_q <= stack_d;
        depth_q <= depth_d;
        rd1_q   <= rd1_d;
        rd2_q   <= rd2_d;
        ovf_q   <= ovf_d;
        udf_q   <= udf_d;
        perr_q  <= perr_d;
    end

    assign rd1         = rd1_q;
    assign rd2         = rd2_q;
    assign depth       = depth_q;
    assign stack_full  = full_c;
    assign stack_empty = empty_c;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;
    assign proto_err   = perr_q;

endmodule

// File: doc/baej_reg_file.md
Name: baej_reg_file

Overview:
- Register file that responds to the multicycle control unit's register-side strobes: RegR1, RegR2, RegW1, RegW2, backup and restore.
- Holds the architectural registers.
- Provides a shadow-window stack: cal pushes the whole register file with backup, and ret pops it with restore.
- Sits in the datapath between the instruction-field decode, the writeback muxes and the ALU operand registers.

Parameters:
- WIDTH, 16, data width of each register.
- NREG, 16, number of architectural registers (address width is clog2(NREG)).
- DEPTH, 8, number of shadow windows the backup stack can hold.
- RET_REG, 1, register index that restore does not overwrite; it carries the return value.

Ports:
- clk  in  1  clock, rising-edge active.
- Reset  in  1  reset Reset, synchronous, active-high.
- RegR1  in  1  latch read port 1.
- RegR2  in  1  latch read port 2.
- ra1  in  clog2(NREG)  read address 1.
- ra2  in  clog2(NREG)  read address 2.
- RegW1  in  1  write enable, port 1 (slt/compare path).
- wa1  in  clog2(NREG)  write address 1.
- wd1  in  WIDTH  write data 1.
- RegW2  in  1  write enable, port 2 (Regsrc mux path).
- wa2  in  clog2(NREG)  write address 2.
- wd2  in  WIDTH  write data 2.
- backup  in  1  push a snapshot of all registers.
- restore  in  1  pop the top snapshot.
- rd1  out  WIDTH  registered read data 1.
- rd2  out  WIDTH  registered read data 2.
- depth  out  clog2(DEPTH)+1  number of windows currently stacked.
- stack_full  out  1  depth == DEPTH.
- stack_empty  out  1  depth == 0.
- overflow  out  1  sticky: backup issued while full.
- underflow  out  1  sticky: restore issued while empty.
- proto_err  out  1  sticky: backup and restore asserted in the same cycle.

Behaviour:
- All state updates on the rising edge of clk.
- Reset (synchronous, high) has priority over every other input. On reset:
  - all registers, rd1, rd2 and depth go to 0;
  - overflow, underflow and proto_err go to 0;
  - stack contents are don't-care.
  - A backup or restore pending in the reset cycle is discarded.
- Reads:
  - rd1 <= regs[ra1] when RegR1 = 1; otherwise rd1 holds.
  - rd2 behaves the same with RegR2 and ra2.
  - Latency is one cycle. Values hold through the later ex/mem states while the strobe is low.
  - Read-before-write: a read in the same cycle as a write to that address returns the old value (without the optional bypass).
- Writes:
  - RegW1 writes wd1 to regs[wa1]; RegW2 writes wd2 to regs[wa2].
  - If both are enabled and wa1 == wa2, port 2 wins.
- backup (not full):
  - stack[depth] <= snapshot of all NREG registers; depth <= depth + 1.
  - The snapshot takes pre-edge values: same-cycle writes land in the live file but not in the snapshot.
- backup while full: no push, depth unchanged, overflow <= 1.
- restore (not empty):
  - every register except RET_REG <= stack[depth-1]; depth <= depth - 1.
  - A same-cycle write to a restored register loses to the restore.
  - A same-cycle write to RET_REG takes effect.
- restore while empty: registers and depth unchanged, underflow <= 1.
- backup and restore in the same cycle: neither operation happens, proto_err <= 1, register writes still apply.
- stack_full and stack_empty are combinational from depth.
- The sticky flags clear only on Reset.
- The stack is LIFO. A wrapped or overflowed push never corrupts existing windows.

Optional Feature:
- Macro: BAEJ_RF_BYPASS_EN.
- Defined: write-to-read forwarding on each read port. If RegRn and a write to ran happen in the same cycle, rdn gets the written data. If both write ports hit ran, port 2's data is forwarded. If restore also hits ran (ran != RET_REG), the restored value is forwarded.
- Undefined: strict read-before-write as above.

Test Plan:
- Reset, then write r3 = 0x1234 via RegW2, then RegR1 with ra1 = 3 -> rd1 = 0x1234 one cycle later; rd1 holds with RegR1 low.
- RegW1 to r5 = 0x00AA and RegW2 to r5 = 0x5500 in the same cycle -> r5 = 0x5500.
- Set r1 = 0x0011 and r2 = 0x0022, backup, write r1 = 0x0099 and r2 = 0x0088, restore -> r1 = 0x0099 (RET_REG), r2 = 0x0022, depth 1 -> 0.
- Nine backups with DEPTH = 8 -> depth = 8, stack_full = 1, overflow = 1. Eight restores -> the original windows return in LIFO order. Ninth restore -> underflow = 1, depth stays 0.
- backup and restore in the same cycle with depth = 2 -> depth stays 2, proto_err = 1. Reset mid-stack -> depth = 0 and all flags clear.
- Write r4 = 0x0F0F and read ra1 = 4 in the same cycle -> rd1 = old value without the macro, 0x0F0F with BAEJ_RF_BYPASS_EN.
